// File: rtl/shift_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// shift_delay_line_pkg
// Shared definitions for the shift_delay_line block:
//   DEF_WIDTH     - default data width (16)
//   calc_dw()     - width of delay/count fields for a given MAX_DEPTH
//   clamp_delay() - maps a requested delay into 1..max_depth
//   ctrl_state_t  - state of the delay-change controller
// Optional feature macro used by the block: SHIFT_DELAY_DATA_CLEAR_EN
// -----------------------------------------------------------------------------
package shift_delay_line_pkg;

    localparam int DEF_WIDTH = 16;

    // Enough bits to hold the values 0..max_depth.
    function automatic int calc_dw(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // 0 is not a legal delay, so it is mapped to 1; anything beyond the
    // physical stage count is mapped to the last stage.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_depth);
        if (req == 0)
            return 1;
        if (req > max_depth)
            return max_depth;
        return req;
    endfunction

    // ST_RUN  : delay_cur is active, input accepted.
    // ST_DRAIN: a delay change is waiting for the active section to empty.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/shift_delay_line_if.sv
// -----------------------------------------------------------------------------
// shift_delay_line_if
// Stream bus of the delay line.
//   si / si_valid : input item and its qualifier (master -> slave)
//   si_ready      : input accepted this cycle when high (slave -> master)
//   so / so_valid : delayed item and its valid tag (slave -> master)
// Handshake: an input item is taken on an enabled clock edge when
// si_valid && si_ready are both high on that edge; si_ready does not depend
// combinationally on si_valid. so/so_valid carry no back-pressure.
// -----------------------------------------------------------------------------
interface shift_delay_line_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] si;
    logic             si_valid;
    logic             si_ready;
    logic [WIDTH-1:0] so;
    logic             so_valid;

    modport master (
        output si, si_valid,
        input  si_ready, so, so_valid
    );

    modport slave (
        input  si, si_valid,
        output si_ready, so, so_valid
    );
endinterface

// File: rtl/shift_delay_ctrl.sv
// -----------------------------------------------------------------------------
// shift_delay_ctrl
// Bookkeeping for the delay line: counts valid entries in the active section,
// holds the requested delay until the active section has drained, then
// switches delay_cur.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clken, flush      shift enable, synchronous tag clear
//   delay_load/sel    delay change request and requested value
//   si_valid          input qualifier
//   tap_valid         valid tag of the currently selected tap stage
//   count             valid entries in stages 0..delay_cur-1
//   delay_cur         active delay
//   state             controller state (ST_DRAIN == change pending)
//   si_ready, accept  input ready / input taken this cycle
//   clear_tags        clear every valid tag on this edge
// -----------------------------------------------------------------------------
module shift_delay_ctrl
    import shift_delay_line_pkg::*;
#(
    parameter int MAX_DEPTH = 8,
    parameter int DEF_DELAY = MAX_DEPTH,
    parameter int DW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          flush,
    input  logic          delay_load,
    input  logic [DW-1:0] delay_sel,
    input  logic          si_valid,
    input  logic          tap_valid,
    output logic [DW-1:0] count,
    output logic [DW-1:0] delay_cur,
    output ctrl_state_t   state,
    output logic          si_ready,
    output logic          accept,
    output logic          clear_tags
);

    ctrl_state_t   state_q, state_n;
    logic [DW-1:0] count_q, count_n;
    logic [DW-1:0] delay_q, delay_n;
    logic [DW-1:0] pend_q, pend_n;
    logic          apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            delay_q <= DW'(DEF_DELAY);
            pend_q  <= DW'(DEF_DELAY);
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            delay_q <= delay_n;
            pend_q  <= pend_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        delay_n    = delay_q;
        pend_n     = pend_q;
        si_ready   = (state_q == ST_RUN);
        accept     = si_valid && (state_q == ST_RUN);
        // An empty active section means no in-flight item can be lost by
        // moving the tap; stale tags beyond the old tap are wiped with it.
        apply      = (state_q == ST_DRAIN) && (count_q == '0);
        clear_tags = flush || apply;

        if (clken)
            count_n = count_q + {{(DW-1){1'b0}}, accept}
                              - {{(DW-1){1'b0}}, tap_valid};

        if (apply) begin
            delay_n = pend_q;
            state_n = ST_RUN;
            count_n = '0;
        end

        if (flush)
            count_n = '0;

        // Checked last so a request arriving on the apply edge re-arms.
        if (delay_load) begin
            pend_n  = DW'(clamp_delay(32'(delay_sel), MAX_DEPTH));
            state_n = ST_DRAIN;
        end
    end

    assign count     = count_q;
    assign delay_cur = delay_q;
    assign state     = state_q;

endmodule

// File: rtl/shift_delay_line.sv
// -----------------------------------------------------------------------------
// shift_delay_line
// Clock-enabled delay line with valid tagging, runtime-selectable depth and
// synchronous flush. Realigns parallel pipelined datapaths.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clken        stages advance only when high
//   flush        clears all valid tags (and data, see macro)
//   delay_sel    requested delay, taken when delay_load=1
//   delay_load   request a delay change
//   bus          stream interface (si, si_valid, si_ready, so, so_valid)
//   count        valid entries in stages 0..delay_cur-1
//   delay_cur    active delay
//   pending      a delay change is waiting to drain
// Macro SHIFT_DELAY_DATA_CLEAR_EN: when defined, data stages are reset by rst
// and zeroed by flush; when undefined they carry no reset (SRL friendly) and
// so is undefined while so_valid=0.
// -----------------------------------------------------------------------------
module shift_delay_line
    import shift_delay_line_pkg::*;
#(
    parameter int   WIDTH     = DEF_WIDTH,
    parameter int   MAX_DEPTH = 8,
    parameter int   DEF_DELAY = MAX_DEPTH,
    localparam int  DW        = calc_dw(MAX_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                flush,
    input  logic [DW-1:0]       delay_sel,
    input  logic                delay_load,
    shift_delay_line_if.slave   bus,
    output logic [DW-1:0]       count,
    output logic [DW-1:0]       delay_cur,
    output logic                pending
);

    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic [WIDTH-1:0]     data_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] valid_q;
    logic [AW-1:0]        tap_idx;
    logic                 accept;
    logic                 clear_tags;
    logic                 si_ready;
    ctrl_state_t          ctrl_state;

    shift_delay_ctrl #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEF_DELAY (DEF_DELAY),
        .DW        (DW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .flush      (flush),
        .delay_load (delay_load),
        .delay_sel  (delay_sel),
        .si_valid   (bus.si_valid),
        .tap_valid  (valid_q[tap_idx]),
        .count      (count),
        .delay_cur  (delay_cur),
        .state      (ctrl_state),
        .si_ready   (si_ready),
        .accept     (accept),
        .clear_tags (clear_tags)
    );

    assign pending = (ctrl_state == ST_DRAIN);

    // delay_cur is always 1..MAX_DEPTH, so delay_cur-1 is a legal stage.
    assign tap_idx = AW'(delay_cur - DW'(1));

    // Valid tags: cleared on flush/apply even when the data stages shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_tags) begin
            valid_q <= '0;
        end else if (clken) begin
            valid_q[0] <= accept;
            for (int i = 1; i < MAX_DEPTH; i++)
                valid_q[i] <= valid_q[i-1];
        end
    end

`ifdef SHIFT_DELAY_DATA_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++)
                data_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_DEPTH; i++)
                data_q[i] <= '0;
        end else if (clken) begin
            data_q[0] <= bus.si;
            for (int i = 1; i < MAX_DEPTH; i++)
                data_q[i] <= data_q[i-1];
        end
    end
`else
    // No reset here so the stages can map onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (clken) begin
            data_q[0] <= bus.si;
            for (int i = 1; i < MAX_DEPTH; i++)
                data_q[i] <= data_q[i-1];
        end
    end
`endif

    assign bus.so       = data_q[tap_idx];
    assign bus.so_valid = valid_q[tap_idx];
    assign bus.si_ready = si_ready;

endmodule

// File: tb/tb_shift_delay_line.sv
// -----------------------------------------------------------------------------
// tb_shift_delay_line
// Directed bench for shift_delay_line (WIDTH=16, MAX_DEPTH=8, DEF_DELAY=8).
// Honours SHIFT_DELAY_DATA_CLEAR_EN for the data-zero checks.
// -----------------------------------------------------------------------------
module tb_shift_delay_line;

    localparam int WIDTH = 16;
    localparam int DW    = 4;

    typedef struct {
        logic             clken;
        logic             flush;
        logic             delay_load;
        logic [DW-1:0]    delay_sel;
        logic [WIDTH-1:0] si;
        logic             si_valid;
        logic             exp_so_valid;
        logic [WIDTH-1:0] exp_so;
        logic [DW-1:0]    exp_count;
        logic [DW-1:0]    exp_delay_cur;
        logic             exp_pending;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] delay_sel = '0;
    logic          delay_load = 1'b0;
    logic [DW-1:0] count;
    logic [DW-1:0] delay_cur;
    logic          pending;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs [20];

    shift_delay_line_if #(.WIDTH(WIDTH)) bus ();

    shift_delay_line #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (8),
        .DEF_DELAY (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .flush      (flush),
        .delay_sel  (delay_sel),
        .delay_load (delay_load),
        .bus        (bus),
        .count      (count),
        .delay_cur  (delay_cur),
        .pending    (pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic ce, input logic fl, input logic dl,
                        input logic [DW-1:0] ds, input logic [WIDTH-1:0] d,
                        input logic v);
        clken       = ce;
        flush       = fl;
        delay_load  = dl;
        delay_sel   = ds;
        bus.si       = d;
        bus.si_valid = v;
        @(posedge clk);
        #1;
        delay_load  = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic sv, input logic [DW-1:0] cnt,
                             input logic [DW-1:0] dc, input logic pd);
        chk({tag, " so_valid"}, 32'(bus.so_valid), 32'(sv));
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " delay_cur"}, 32'(delay_cur), 32'(dc));
        chk({tag, " pending"}, 32'(pending), 32'(pd));
        chk({tag, " si_ready"}, 32'(bus.si_ready), 32'(!pd));
    endtask

    initial begin
        bus.si       = '0;
        bus.si_valid = 1'b0;

        // Stream 0x0001..0x0010 through delay 8, then four idle cycles.
        // Item k is sampled on edge k and shows after edge k+7.
        for (int e = 1; e <= 20; e++) begin
            vecs[e-1].clken         = 1'b1;
            vecs[e-1].flush         = 1'b0;
            vecs[e-1].delay_load    = 1'b0;
            vecs[e-1].delay_sel     = '0;
            vecs[e-1].si            = (e <= 16) ? 16'(e) : 16'h0000;
            vecs[e-1].si_valid      = (e <= 16);
            vecs[e-1].exp_so_valid  = (e >= 8);
            vecs[e-1].exp_so        = 16'(e - 7);
            vecs[e-1].exp_count     = (e <= 8) ? DW'(e) : ((e <= 16) ? DW'(8) : DW'(24 - e));
            vecs[e-1].exp_delay_cur = DW'(8);
            vecs[e-1].exp_pending   = 1'b0;
        end

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 4'd0, 4'd8, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- full-depth stream ----------------
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].clken, vecs[i].flush, vecs[i].delay_load, vecs[i].delay_sel,
                 vecs[i].si, vecs[i].si_valid);
            chk($sformatf("stream[%0d] so_valid", i), 32'(bus.so_valid), 32'(vecs[i].exp_so_valid));
            if (vecs[i].exp_so_valid)
                chk($sformatf("stream[%0d] so", i), 32'(bus.so), 32'(vecs[i].exp_so));
            chk($sformatf("stream[%0d] count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("stream[%0d] delay_cur", i), 32'(delay_cur), 32'(vecs[i].exp_delay_cur));
            chk($sformatf("stream[%0d] pending", i), 32'(pending), 32'(vecs[i].exp_pending));
        end

        // ---------------- delay change 8 -> 2 with 4 items in flight ----------------
        step(1, 0, 1, 4'd2, 16'h0000, 0);
        chk_state("load2", 1'b1, 4'd3, 4'd8, 1'b1);
        chk("load2 so", 32'(bus.so), 32'h000E);
        // Offered input must be ignored while the change is pending.
        step(1, 0, 0, 4'd0, 16'hDEAD, 1);
        chk_state("drain1", 1'b1, 4'd2, 4'd8, 1'b1);
        chk("drain1 so", 32'(bus.so), 32'h000F);
        step(1, 0, 0, 4'd0, 16'hDEAD, 1);
        chk_state("drain2", 1'b1, 4'd1, 4'd8, 1'b1);
        chk("drain2 so", 32'(bus.so), 32'h0010);
        step(1, 0, 0, 4'd0, 16'hDEAD, 1);
        chk_state("drain3", 1'b0, 4'd0, 4'd8, 1'b1);
        step(1, 0, 0, 4'd0, 16'hDEAD, 1);
        chk_state("apply2", 1'b0, 4'd0, 4'd2, 1'b0);
        step(1, 0, 0, 4'd0, 16'h0A01, 1);
        chk_state("d2 in", 1'b0, 4'd1, 4'd2, 1'b0);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("d2 out", 1'b1, 4'd1, 4'd2, 1'b0);
        chk("d2 out so", 32'(bus.so), 32'h0A01);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("d2 gone", 1'b0, 4'd0, 4'd2, 1'b0);

        // ---------------- clamp 0 -> 1, delay 1 latency ----------------
        step(1, 0, 1, 4'd0, 16'h0000, 0);
        chk_state("load0", 1'b0, 4'd0, 4'd2, 1'b1);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("apply1", 1'b0, 4'd0, 4'd1, 1'b0);
        step(1, 0, 0, 4'd0, 16'h1111, 1);
        chk_state("d1 in", 1'b1, 4'd1, 4'd1, 1'b0);
        chk("d1 so", 32'(bus.so), 32'h1111);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("d1 gone", 1'b0, 4'd0, 4'd1, 1'b0);

        // ---------------- clamp 15 -> 8, reload on the apply edge ----------------
        step(1, 0, 1, 4'd15, 16'h0000, 0);
        chk_state("load15", 1'b0, 4'd0, 4'd1, 1'b1);
        step(1, 0, 1, 4'd3, 16'h0000, 0);
        chk_state("apply8 reload3", 1'b0, 4'd0, 4'd8, 1'b1);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("apply3", 1'b0, 4'd0, 4'd3, 1'b0);

        // ---------------- clken 1010... at delay 3 ----------------
        step(1, 0, 0, 4'd0, 16'hABCD, 1);
        chk_state("ce e1", 1'b0, 4'd1, 4'd3, 1'b0);
        step(0, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce d1", 1'b0, 4'd1, 4'd3, 1'b0);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce e2", 1'b0, 4'd1, 4'd3, 1'b0);
        step(0, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce d2", 1'b0, 4'd1, 4'd3, 1'b0);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce e3", 1'b1, 4'd1, 4'd3, 1'b0);
        chk("ce e3 so", 32'(bus.so), 32'hABCD);
        step(0, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce d3", 1'b1, 4'd1, 4'd3, 1'b0);
        chk("ce d3 so", 32'(bus.so), 32'hABCD);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("ce e4", 1'b0, 4'd0, 4'd3, 1'b0);

        // ---------------- flush with clken=0 and a concurrent load ----------------
        step(1, 0, 1, 4'd8, 16'h0000, 0);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("apply8", 1'b0, 4'd0, 4'd8, 1'b0);
        for (int k = 1; k <= 5; k++)
            step(1, 0, 0, 4'd0, 16'h0B00 + 16'(k), 1);
        chk_state("five in", 1'b0, 4'd5, 4'd8, 1'b0);
        step(0, 1, 1, 4'd4, 16'h0000, 0);
        chk_state("flush", 1'b0, 4'd0, 4'd8, 1'b1);
`ifdef SHIFT_DELAY_DATA_CLEAR_EN
        chk("flush so", 32'(bus.so), 32'h0000);
`endif
        step(0, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("flush apply4", 1'b0, 4'd0, 4'd4, 1'b0);
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("flush no ghost", 1'b0, 4'd0, 4'd4, 1'b0);

        // ---------------- reset mid-stream with a pending change ----------------
        for (int k = 1; k <= 3; k++)
            step(1, 0, 0, 4'd0, 16'h0C00 + 16'(k), 1);
        step(1, 0, 1, 4'd2, 16'h0C04, 1);
        chk_state("pre-rst", 1'b1, 4'd4, 4'd4, 1'b1);
        chk("pre-rst so", 32'(bus.so), 32'h0C01);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async rst", 1'b0, 4'd0, 4'd8, 1'b0);
`ifdef SHIFT_DELAY_DATA_CLEAR_EN
        chk("async rst so", 32'(bus.so), 32'h0000);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 4'd0, 16'h0000, 0);
        chk_state("post-rst", 1'b0, 4'd0, 4'd8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
